// File: rtl/systolic_mm_ctrl.sv
// systolic_mm_ctrl: sequences one 3x3 systolic array job.
// Latches operands, clears and runs the array, captures the nine PE results behind a valid/ready handshake.
module systolic_mm_ctrl #(
  parameter int WIDTH       = 4,
  parameter int ROW         = 3,
  parameter int COLOUM      = 3,
  parameter int CALC_CYCLES = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  output logic                     o_start_ready,
  input  logic                     i_abort,
  input  logic [WIDTH*ROW-1:0]     i_a_row_1,
  input  logic [WIDTH*ROW-1:0]     i_a_row_2,
  input  logic [WIDTH*ROW-1:0]     i_a_row_3,
  input  logic [WIDTH*COLOUM-1:0]  i_b_coloum_1,
  input  logic [WIDTH*COLOUM-1:0]  i_b_coloum_2,
  input  logic [WIDTH*COLOUM-1:0]  i_b_coloum_3,
  output logic [WIDTH*ROW-1:0]     o_arr_a_row_1,
  output logic [WIDTH*ROW-1:0]     o_arr_a_row_2,
  output logic [WIDTH*ROW-1:0]     o_arr_a_row_3,
  output logic [WIDTH*COLOUM-1:0]  o_arr_b_coloum_1,
  output logic [WIDTH*COLOUM-1:0]  o_arr_b_coloum_2,
  output logic [WIDTH*COLOUM-1:0]  o_arr_b_coloum_3,
  output logic                     o_arr_rst,
  input  logic [2*WIDTH:0]         i_arr_out_1x1,
  input  logic [2*WIDTH:0]         i_arr_out_1x2,
  input  logic [2*WIDTH:0]         i_arr_out_1x3,
  input  logic [2*WIDTH:0]         i_arr_out_2x1,
  input  logic [2*WIDTH:0]         i_arr_out_2x2,
  input  logic [2*WIDTH:0]         i_arr_out_2x3,
  input  logic [2*WIDTH:0]         i_arr_out_3x1,
  input  logic [2*WIDTH:0]         i_arr_out_3x2,
  input  logic [2*WIDTH:0]         i_arr_out_3x3,
  output logic [2*WIDTH:0]         o_c_1x1,
  output logic [2*WIDTH:0]         o_c_1x2,
  output logic [2*WIDTH:0]         o_c_1x3,
  output logic [2*WIDTH:0]         o_c_2x1,
  output logic [2*WIDTH:0]         o_c_2x2,
  output logic [2*WIDTH:0]         o_c_2x3,
  output logic [2*WIDTH:0]         o_c_3x1,
  output logic [2*WIDTH:0]         o_c_3x2,
  output logic [2*WIDTH:0]         o_c_3x3,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic                     o_busy
);
  localparam int AW = WIDTH * ROW;
  localparam int BW = WIDTH * COLOUM;
  localparam int CW = 2 * WIDTH + 1;
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;
  state_t          r_state, w_next;
  logic [7:0]      r_cnt;
  logic [AW-1:0]   r_a [3];
  logic [BW-1:0]   r_b [3];
  logic [CW-1:0]   r_c [9];
  logic [AW-1:0]   w_a [3];
  logic [BW-1:0]   w_b [3];
  logic [CW-1:0]   w_out [9];
  logic            w_accept, w_capture, w_load;
  assign w_a   = '{i_a_row_1, i_a_row_2, i_a_row_3};
  assign w_b   = '{i_b_coloum_1, i_b_coloum_2, i_b_coloum_3};
  assign w_out = '{i_arr_out_1x1, i_arr_out_1x2, i_arr_out_1x3,
                   i_arr_out_2x1, i_arr_out_2x2, i_arr_out_2x3,
                   i_arr_out_3x1, i_arr_out_3x2, i_arr_out_3x3};
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = i_start;
        w_next   = i_start ? S_CLEAR : S_IDLE;
      end
      S_CLEAR: begin
        w_load = !i_abort;
        w_next = i_abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        w_capture = !i_abort && r_cnt == 8'd0;
        w_next    = i_abort ? S_IDLE : (r_cnt == 8'd0 ? S_DONE : S_RUN);
      end
      S_DONE:  w_next = i_res_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '{default: '0};
      r_b     <= '{default: '0};
      r_c     <= '{default: '0};
    end else begin
      r_state <= w_next;
      if (w_load)
        r_cnt <= 8'(CALC_CYCLES - 1);
      else if (r_state == S_RUN && r_cnt != 8'd0)
        r_cnt <= r_cnt - 8'd1;
      if (w_accept) begin
        r_a <= w_a;
        r_b <= w_b;
      end
      if (w_capture)
        r_c <= w_out;
    end
  end
  // Flags decode only the state register, so no input reaches an output combinationally.
  assign o_start_ready    = r_state == S_IDLE;
  assign o_busy           = r_state != S_IDLE;
  assign o_res_valid      = r_state == S_DONE;
  assign o_arr_rst        = r_state != S_RUN;
  assign o_arr_a_row_1    = r_a[0];
  assign o_arr_a_row_2    = r_a[1];
  assign o_arr_a_row_3    = r_a[2];
  assign o_arr_b_coloum_1 = r_b[0];
  assign o_arr_b_coloum_2 = r_b[1];
  assign o_arr_b_coloum_3 = r_b[2];
  assign o_c_1x1          = r_c[0];
  assign o_c_1x2          = r_c[1];
  assign o_c_1x3          = r_c[2];
  assign o_c_2x1          = r_c[3];
  assign o_c_2x2          = r_c[4];
  assign o_c_2x3          = r_c[5];
  assign o_c_3x1          = r_c[6];
  assign o_c_3x2          = r_c[7];
  assign o_c_3x3          = r_c[8];
endmodule
